eth_rx_frame_reader: RTL and testbench
======================================

// Module: eth_rx_frame_reader
// PURPOSE
//  AXI4-Stream sink at the Ethernet RX end: drains frames leaving the RX axis frame FIFO into a 2-slot ping-pong
//  packet buffer and exposes completed frames (length plus random-access word reads) to the host/MMIO side.
//  Never back-pressures the link once out of reset: frames with no free slot, oversize or bad are dropped whole.
// PARAMETERS
//  DATA_WIDTH        32    axis data width in bits, multiple of 8
//  KEEP_WIDTH        DATA_WIDTH/8   tkeep width (bytes per beat)
//  MAX_FRAME_BYTES   2048  bytes per slot, power of 2, multiple of KEEP_WIDTH
//  USER_BAD_FRAME_VALUE 1'b1   tuser value on the tlast beat that marks a bad frame
//  (local) WORD_AW = $clog2(MAX_FRAME_BYTES/KEEP_WIDTH); LEN_W = $clog2(MAX_FRAME_BYTES+1)
// PORTS
//  clk                input   1           clock, all logic posedge
//  rst                input   1           asynchronous, active-high reset
//  s_axis_tdata       input   DATA_WIDTH  frame data, byte 0 in bits [7:0]
//  s_axis_tkeep       input   KEEP_WIDTH  byte enables; all-ones except on the tlast beat
//  s_axis_tvalid      input   1           beat valid
//  s_axis_tready      output  1           beat accepted (registered)
//  s_axis_tlast       input   1           last beat of frame
//  s_axis_tuser       input   1           bad-frame marker, sampled on the tlast beat only
//  rd_frame_valid     output  1           head slot holds a committed frame
//  rd_frame_len       output  LEN_W       byte length of head frame; 0 when !rd_frame_valid
//  rd_addr            input   WORD_AW     word index into head frame
//  rd_data            output  DATA_WIDTH  word at rd_addr, 1-cycle latency
//  rd_release         input   1           pulse: host done with head frame, free slot
//  status_good_frame  output  1           1-cycle pulse per committed frame
//  status_bad_frame   output  1           1-cycle pulse per frame dropped for tuser or zero length
//  status_overflow    output  1           1-cycle pulse per frame dropped for oversize or no free slot
// BEHAVIOUR
//  Reset (async assert, sync release): FSM=RESYNC, wr_slot=rd_slot=0, slot_full=2'b00, lengths=0, s_axis_tready=0,
//   all status pulses 0, rd_frame_valid=0, rd_frame_len=0, rd_data=0. s_axis_tready=1 from the first edge after release.
//  Beat accepted = tvalid & tready. FSM states:
//   RESYNC: discard beats until an accepted tlast -> IDLE (guards against reset landing mid-frame; no status pulse).
//   IDLE:   on an accepted beat: if slot_full[wr_slot] -> DROP (tlast on same beat: stay IDLE, overflow pulse)
//           else write word 0 and go to RECV, or finish immediately if tlast.
//   RECV:   write beat at {wr_slot, word_cnt}; word_cnt++; byte_cnt += KEEP_WIDTH (non-last) or popcount(tkeep) (last).
//           Accepted non-last beat when word_cnt == 2**WORD_AW-1 -> DROP (oversize).
//   DROP:   discard beats; on accepted tlast -> IDLE, pulse status_overflow.
//  Frame completion (accepted tlast beat in IDLE/RECV with a slot held):
//   tuser==USER_BAD_FRAME_VALUE or final byte count 0 -> discard, pulse status_bad_frame.
//   Otherwise len[wr_slot]<=byte count, slot_full[wr_slot]<=1, wr_slot toggles, pulse status_good_frame.
//   A frame of exactly MAX_FRAME_BYTES commits; one beat more is oversize.
//  Host side: rd_frame_valid = slot_full[rd_slot]; rd_frame_len = len[rd_slot] when valid else 0.
//   rd_data <= mem[{rd_slot, rd_addr}] every cycle; contents of a non-valid slot are don't-care.
//   rd_release while rd_frame_valid: clear slot_full[rd_slot], toggle rd_slot. rd_release while !valid: ignored.
//  Simultaneous commit and release act on different slots; both take effect the same edge.
//  A freed slot is usable by a frame whose first beat arrives on the edge following the release.
//  Counters are exact-width; word_cnt never wraps (DROP is entered first). Dropped beats never write memory.
// STRUCTURE
//  Shared ethernet package: FSM state enum (RESYNC/IDLE/RECV/DROP) and the popcount function for tkeep.
//  Sub-module eth_rx_frame_buf_mem: 1W1R synchronous RAM, 2*2**WORD_AW x DATA_WIDTH, registered read.
//  Top level holds FSM, counters, slot bookkeeping and status pulses.
// TESTING
//  Reset, then 1 beat tlast, tkeep=4'b0111 -> after 1 RESYNC-flush frame, second such frame: valid=1, len=3, good pulse.
//  Two 64-byte frames, no release -> both slots full; third frame dropped, overflow pulse, tready held 1.
//  Release slot 0 on the edge the third frame's tlast commits into slot 1 -> both take effect; rd_frame_len = slot 1 len.
//  Frame of 2048 bytes commits (len=2048); 2052-byte frame -> overflow pulse, no commit, next frame lands in same slot.
//  tuser=1 on tlast -> bad pulse, slot not consumed; rd_addr=5 after good frame returns byte 20..23 one cycle later.
//  Assert rst mid-RECV -> all outputs reset immediately; trailing beats discarded until tlast, next frame commits to slot 0.

Source files
------------

// File: rtl/eth_rx_frame_reader_pkg.sv
// Shared types and helpers for the Ethernet RX frame reader.
package eth_rx_frame_reader_pkg;

  typedef enum logic [1:0] {
    ST_RESYNC = 2'd0,
    ST_IDLE   = 2'd1,
    ST_RECV   = 2'd2,
    ST_DROP   = 2'd3
  } rx_state_e;

  localparam int unsigned KEEP_MAX_W = 64;
  localparam int unsigned POP_W      = 8;

  // Number of enabled bytes in a tkeep vector (zero-extended to KEEP_MAX_W).
  function automatic logic [POP_W-1:0] keep_popcount(input logic [KEEP_MAX_W-1:0] keep);
    logic [POP_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < KEEP_MAX_W; i++) begin
      cnt = cnt + POP_W'(keep[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/eth_rx_frame_reader_if.sv
// AXI4-Stream link carrying received Ethernet frames.
interface eth_rx_frame_reader_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic                  tuser;

  modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/eth_rx_frame_buf_mem.sv
// Ping-pong packet buffer storage: 1W1R synchronous RAM with registered read port.
module eth_rx_frame_buf_mem #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_W     = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DATA_WIDTH-1:0] rd_data_d;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data_d = mem_q[rd_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/eth_rx_frame_reader.sv
// Drains RX AXI-Stream frames into a 2-slot ping-pong buffer and exposes completed
// frames to the host; never back-pressures once out of reset.
module eth_rx_frame_reader
  import eth_rx_frame_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH           = 32,
  parameter int unsigned KEEP_WIDTH           = DATA_WIDTH / 8,
  parameter int unsigned MAX_FRAME_BYTES      = 2048,
  parameter logic        USER_BAD_FRAME_VALUE = 1'b1,
  localparam int unsigned WORD_AW             = $clog2(MAX_FRAME_BYTES / KEEP_WIDTH),
  localparam int unsigned LEN_W               = $clog2(MAX_FRAME_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  eth_rx_frame_reader_if.slave   s_axis,
  output logic                   rd_frame_valid,
  output logic [LEN_W-1:0]       rd_frame_len,
  input  logic [WORD_AW-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0]  rd_data,
  input  logic                   rd_release,
  output logic                   status_good_frame,
  output logic                   status_bad_frame,
  output logic                   status_overflow
);

  rx_state_e          state_q, state_d;
  logic               tready_q, tready_d;
  logic               wr_slot_q, wr_slot_d;
  logic               rd_slot_q, rd_slot_d;
  logic [1:0]         slot_full_q, slot_full_d;
  logic [LEN_W-1:0]   len_q [2];
  logic [LEN_W-1:0]   len_d [2];
  logic [WORD_AW-1:0] word_cnt_q, word_cnt_d;
  logic [LEN_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic               good_q, good_d;
  logic               bad_q, bad_d;
  logic               ovf_q, ovf_d;
  logic               rd_valid_q, rd_valid_d;
  logic [LEN_W-1:0]   rd_len_q, rd_len_d;

  logic               beat_c;
  logic               last_c;
  logic               word_full_c;
  logic               slot_free_c;
  logic [LEN_W-1:0]   keep_bytes_c;
  logic [LEN_W-1:0]   frame_bytes_c;
  logic               frame_bad_c;
  logic               complete_c;
  logic               mem_wr_en_c;
  logic [WORD_AW:0]   mem_wr_addr_c;
  logic [WORD_AW:0]   mem_rd_addr_c;

  assign beat_c        = s_axis.tvalid & tready_q;
  assign last_c        = beat_c & s_axis.tlast;
  assign word_full_c   = (word_cnt_q == {WORD_AW{1'b1}});
  assign slot_free_c   = ~slot_full_q[wr_slot_q];
  assign keep_bytes_c  = LEN_W'(keep_popcount(KEEP_MAX_W'(s_axis.tkeep)));
  // A tlast in IDLE is a single-beat frame, so the running count does not apply.
  assign frame_bytes_c = (state_q == ST_IDLE) ? keep_bytes_c : (byte_cnt_q + keep_bytes_c);
  assign frame_bad_c   = (s_axis.tuser == USER_BAD_FRAME_VALUE) || (frame_bytes_c == '0);
  assign mem_rd_addr_c = {rd_slot_q, rd_addr};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RESYNC;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RESYNC: if (last_c) state_d = ST_IDLE;
      ST_IDLE: begin
        if (beat_c && !s_axis.tlast) begin
          state_d = slot_free_c ? ST_RECV : ST_DROP;
        end
      end
      ST_RECV: begin
        if (beat_c) begin
          if (s_axis.tlast) begin
            state_d = ST_IDLE;
          end else if (word_full_c) begin
            state_d = ST_DROP;
          end
        end
      end
      ST_DROP: if (last_c) state_d = ST_IDLE;
      default: state_d = ST_RESYNC;
    endcase
  end

  always_comb begin
    tready_d      = 1'b1;
    wr_slot_d     = wr_slot_q;
    rd_slot_d     = rd_slot_q;
    slot_full_d   = slot_full_q;
    len_d         = len_q;
    word_cnt_d    = word_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    good_d        = 1'b0;
    bad_d         = 1'b0;
    ovf_d         = 1'b0;
    complete_c    = 1'b0;
    mem_wr_en_c   = 1'b0;
    mem_wr_addr_c = {wr_slot_q, word_cnt_q};

    unique case (state_q)
      ST_IDLE: begin
        if (beat_c) begin
          if (!slot_free_c) begin
            ovf_d = s_axis.tlast;
          end else begin
            mem_wr_en_c   = 1'b1;
            mem_wr_addr_c = {wr_slot_q, WORD_AW'(0)};
            word_cnt_d    = WORD_AW'(1);
            byte_cnt_d    = LEN_W'(KEEP_WIDTH);
            complete_c    = s_axis.tlast;
          end
        end
      end
      ST_RECV: begin
        // The beat that would overrun the slot goes to DROP unwritten.
        if (beat_c && (s_axis.tlast || !word_full_c)) begin
          mem_wr_en_c = 1'b1;
          complete_c  = s_axis.tlast;
          if (!s_axis.tlast) begin
            word_cnt_d = word_cnt_q + WORD_AW'(1);
            byte_cnt_d = byte_cnt_q + LEN_W'(KEEP_WIDTH);
          end
        end
      end
      ST_DROP: ovf_d = last_c;
      default: ;
    endcase

    if (complete_c) begin
      if (frame_bad_c) begin
        bad_d = 1'b1;
      end else begin
        len_d[wr_slot_q]       = frame_bytes_c;
        slot_full_d[wr_slot_q] = 1'b1;
        wr_slot_d              = ~wr_slot_q;
        good_d                 = 1'b1;
      end
    end

    // A commit only targets a free slot, so it never collides with the release.
    if (rd_release && slot_full_q[rd_slot_q]) begin
      slot_full_d[rd_slot_q] = 1'b0;
      rd_slot_d              = ~rd_slot_q;
    end

    rd_valid_d = slot_full_d[rd_slot_d];
    rd_len_d   = rd_valid_d ? len_d[rd_slot_d] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tready_q    <= 1'b0;
      wr_slot_q   <= 1'b0;
      rd_slot_q   <= 1'b0;
      slot_full_q <= 2'b00;
      len_q[0]    <= '0;
      len_q[1]    <= '0;
      word_cnt_q  <= '0;
      byte_cnt_q  <= '0;
      good_q      <= 1'b0;
      bad_q       <= 1'b0;
      ovf_q       <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_len_q    <= '0;
    end else begin
      tready_q    <= tready_d;
      wr_slot_q   <= wr_slot_d;
      rd_slot_q   <= rd_slot_d;
      slot_full_q <= slot_full_d;
      len_q[0]    <= len_d[0];
      len_q[1]    <= len_d[1];
      word_cnt_q  <= word_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
      ovf_q       <= ovf_d;
      rd_valid_q  <= rd_valid_d;
      rd_len_q    <= rd_len_d;
    end
  end

  eth_rx_frame_buf_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_W     (WORD_AW + 1)
  ) u_buf_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (mem_wr_en_c),
    .wr_addr (mem_wr_addr_c),
    .wr_data (s_axis.tdata),
    .rd_addr (mem_rd_addr_c),
    .rd_data (rd_data)
  );

  assign s_axis.tready     = tready_q;
  assign rd_frame_valid    = rd_valid_q;
  assign rd_frame_len      = rd_len_q;
  assign status_good_frame = good_q;
  assign status_bad_frame  = bad_q;
  assign status_overflow   = ovf_q;

endmodule

// File: tb/tb_eth_rx_frame_reader.sv
// Directed self-checking bench for eth_rx_frame_reader.
module tb_eth_rx_frame_reader;

  localparam int unsigned DW  = 32;
  localparam int unsigned KW  = 4;
  localparam int unsigned WAW = 9;
  localparam int unsigned LW  = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_frame_valid;
  logic [LW-1:0] rd_frame_len;
  logic [WAW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_release;
  logic          status_good_frame;
  logic          status_bad_frame;
  logic          status_overflow;

  int checks = 0;
  int errors = 0;
  logic got_good, got_bad, got_ovf, tready_low;
  logic [31:0] rword;

  eth_rx_frame_reader_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) axis ();

  eth_rx_frame_reader #(
    .DATA_WIDTH (DW),
    .KEEP_WIDTH (KW),
    .MAX_FRAME_BYTES (2048),
    .USER_BAD_FRAME_VALUE (1'b1)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .s_axis            (axis),
    .rd_frame_valid    (rd_frame_valid),
    .rd_frame_len      (rd_frame_len),
    .rd_addr           (rd_addr),
    .rd_data           (rd_data),
    .rd_release        (rd_release),
    .status_good_frame (status_good_frame),
    .status_bad_frame  (status_bad_frame),
    .status_overflow   (status_overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_word(input logic [7:0] base, input int w);
    logic [31:0] r;
    for (int j = 0; j < 4; j++) r[8*j +: 8] = base + 8'(4 * w + j);
    return r;
  endfunction

  task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                            input logic u, input logic rel);
    int n;
    @(negedge clk);
    axis.tvalid = 1'b1; axis.tdata = d; axis.tkeep = k; axis.tlast = l; axis.tuser = u;
    rd_release = rel;
    n = 0;
    while (axis.tready !== 1'b1 && n < 20) begin
      tready_low = 1'b1;
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      errors++;
      $display("FAIL beat_timeout: tready=%b required 1", axis.tready);
    end
  endtask

  task automatic send_frame(input int nbytes, input logic [7:0] base, input logic user,
                            input logic rel_last);
    int nb;
    int rem;
    logic [31:0] d;
    logic [3:0] k;
    nb = (nbytes == 0) ? 1 : (nbytes + 3) / 4;
    for (int b = 0; b < nb; b++) begin
      k = 4'hf;
      if (b == nb - 1) begin
        rem = nbytes - 4 * b;
        k = (rem >= 4) ? 4'hf : 4'((1 << rem) - 1);
      end
      d = '0;
      for (int j = 0; j < 4; j++) if (k[j]) d[8*j +: 8] = base + 8'(4 * b + j);
      drive_beat(d, k, b == nb - 1, (b == nb - 1) ? user : 1'b0, (b == nb - 1) ? rel_last : 1'b0);
    end
    @(negedge clk);
    axis.tvalid = 1'b0; axis.tlast = 1'b0; axis.tuser = 1'b0; rd_release = 1'b0;
    got_good = status_good_frame; got_bad = status_bad_frame; got_ovf = status_overflow;
  endtask

  task automatic release_head();
    @(negedge clk); rd_release = 1'b1;
    @(negedge clk); rd_release = 1'b0;
  endtask

  task automatic read_word(input logic [WAW-1:0] a, output logic [31:0] dout);
    @(negedge clk); rd_addr = a;
    @(negedge clk); dout = rd_data;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); @(negedge clk); rst = 1'b0;
    send_frame(4, 8'hEE, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    axis.tvalid = 1'b0; axis.tdata = '0; axis.tkeep = '0; axis.tlast = 1'b0; axis.tuser = 1'b0;
    rd_addr = '0; rd_release = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++; if (axis.tready !== 1'b0) begin errors++; $display("FAIL reset_tready: got %b required 0", axis.tready); end
    checks++; if (rd_frame_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", rd_frame_valid); end
    checks++; if (rd_frame_len !== '0) begin errors++; $display("FAIL reset_len: got %0d required 0", rd_frame_len); end
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data: got %h required 0", rd_data); end
    checks++; if ({status_good_frame, status_bad_frame, status_overflow} !== 3'b000) begin
      errors++; $display("FAIL reset_status: got %b required 000", {status_good_frame, status_bad_frame, status_overflow}); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (axis.tready !== 1'b1) begin errors++; $display("FAIL tready_after_release: got %b required 1", axis.tready); end
  endtask

  task automatic test_resync_small();
    send_frame(3, 8'hA0, 1'b0, 1'b0);
    checks++; if (got_good !== 1'b0 || rd_frame_valid !== 1'b0) begin
      errors++; $display("FAIL resync_flush: good=%b valid=%b required 0 0", got_good, rd_frame_valid); end
    send_frame(3, 8'hB0, 1'b0, 1'b0);
    checks++; if (got_good !== 1'b1) begin errors++; $display("FAIL small_good: got %b required 1", got_good); end
    checks++; if (rd_frame_valid !== 1'b1 || rd_frame_len !== 12'd3) begin
      errors++; $display("FAIL small_len: valid=%b len=%0d required 1 3", rd_frame_valid, rd_frame_len); end
    read_word('0, rword);
    checks++; if (rword !== 32'h00B2B1B0) begin errors++; $display("FAIL small_data: got %h required 00b2b1b0", rword); end
    release_head();
    checks++; if (rd_frame_valid !== 1'b0 || rd_frame_len !== '0) begin
      errors++; $display("FAIL small_release: valid=%b len=%0d required 0 0", rd_frame_valid, rd_frame_len); end
  endtask

  task automatic test_two_slots_overflow();
    do_reset();
    send_frame(64, 8'h10, 1'b0, 1'b0);
    send_frame(64, 8'h60, 1'b0, 1'b0);
    checks++; if (got_good !== 1'b1 || rd_frame_len !== 12'd64) begin
      errors++; $display("FAIL two_slots: good=%b len=%0d required 1 64", got_good, rd_frame_len); end
    tready_low = 1'b0;
    send_frame(64, 8'h20, 1'b0, 1'b0);
    checks++; if (got_ovf !== 1'b1 || got_good !== 1'b0) begin
      errors++; $display("FAIL third_overflow: ovf=%b good=%b required 1 0", got_ovf, got_good); end
    checks++; if (tready_low !== 1'b0) begin errors++; $display("FAIL tready_held: low_seen=%b required 0", tready_low); end
    read_word(9'd5, rword);
    checks++; if (rword !== exp_word(8'h10, 5)) begin
      errors++; $display("FAIL head_word5: got %h required %h", rword, exp_word(8'h10, 5)); end
  endtask

  task automatic test_release_commit_same_edge();
    do_reset();
    send_frame(64, 8'h10, 1'b0, 1'b0);
    send_frame(12, 8'h30, 1'b0, 1'b1);
    checks++; if (got_good !== 1'b1 || rd_frame_valid !== 1'b1 || rd_frame_len !== 12'd12) begin
      errors++; $display("FAIL rel_commit: good=%b valid=%b len=%0d required 1 1 12", got_good, rd_frame_valid, rd_frame_len); end
    read_word('0, rword);
    checks++; if (rword !== exp_word(8'h30, 0)) begin
      errors++; $display("FAIL rel_commit_data: got %h required %h", rword, exp_word(8'h30, 0)); end
    send_frame(8, 8'h50, 1'b0, 1'b0);
    checks++; if (got_good !== 1'b1 || rd_frame_len !== 12'd12) begin
      errors++; $display("FAIL freed_slot_reuse: good=%b len=%0d required 1 12", got_good, rd_frame_len); end
    release_head();
    checks++; if (rd_frame_len !== 12'd8) begin errors++; $display("FAIL second_head_len: got %0d required 8", rd_frame_len); end
    release_head();
    release_head();
    checks++; if (rd_frame_valid !== 1'b0) begin errors++; $display("FAIL empty_after_release: got %b required 0", rd_frame_valid); end
    send_frame(16, 8'h70, 1'b0, 1'b0);
    checks++; if (rd_frame_valid !== 1'b1 || rd_frame_len !== 12'd16) begin
      errors++; $display("FAIL release_ignored: valid=%b len=%0d required 1 16", rd_frame_valid, rd_frame_len); end
    release_head();
  endtask

  task automatic test_max_frame();
    send_frame(2048, 8'h00, 1'b0, 1'b0);
    checks++; if (got_good !== 1'b1 || rd_frame_len !== 12'd2048) begin
      errors++; $display("FAIL max_commit: good=%b len=%0d required 1 2048", got_good, rd_frame_len); end
    read_word(9'd511, rword);
    checks++; if (rword !== 32'hFFFEFDFC) begin errors++; $display("FAIL max_last_word: got %h required fffefdfc", rword); end
    release_head();
    send_frame(2052, 8'h00, 1'b0, 1'b0);
    checks++; if (got_ovf !== 1'b1 || got_good !== 1'b0 || rd_frame_valid !== 1'b0) begin
      errors++; $display("FAIL oversize: ovf=%b good=%b valid=%b required 1 0 0", got_ovf, got_good, rd_frame_valid); end
    send_frame(16, 8'h40, 1'b0, 1'b0);
    checks++; if (rd_frame_valid !== 1'b1 || rd_frame_len !== 12'd16) begin
      errors++; $display("FAIL after_oversize: valid=%b len=%0d required 1 16", rd_frame_valid, rd_frame_len); end
    release_head();
  endtask

  task automatic test_bad_frame();
    send_frame(20, 8'h00, 1'b1, 1'b0);
    checks++; if (got_bad !== 1'b1 || got_good !== 1'b0 || rd_frame_valid !== 1'b0) begin
      errors++; $display("FAIL tuser_bad: bad=%b good=%b valid=%b required 1 0 0", got_bad, got_good, rd_frame_valid); end
    send_frame(0, 8'h00, 1'b0, 1'b0);
    checks++; if (got_bad !== 1'b1 || rd_frame_valid !== 1'b0) begin
      errors++; $display("FAIL zero_len_bad: bad=%b valid=%b required 1 0", got_bad, rd_frame_valid); end
    send_frame(24, 8'h80, 1'b0, 1'b0);
    checks++; if (got_good !== 1'b1 || rd_frame_len !== 12'd24) begin
      errors++; $display("FAIL after_bad: good=%b len=%0d required 1 24", got_good, rd_frame_len); end
    read_word(9'd5, rword);
    checks++; if (rword !== 32'h97969594) begin errors++; $display("FAIL rd_addr5: got %h required 97969594", rword); end
    release_head();
  endtask

  task automatic test_reset_mid_recv();
    send_frame(8, 8'h11, 1'b0, 1'b0);
    for (int b = 0; b < 3; b++) drive_beat(exp_word(8'hC0, b), 4'hf, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1; axis.tvalid = 1'b0;
    #1;
    checks++; if (rd_frame_valid !== 1'b0 || rd_frame_len !== '0) begin
      errors++; $display("FAIL midreset_valid: valid=%b len=%0d required 0 0", rd_frame_valid, rd_frame_len); end
    checks++; if (axis.tready !== 1'b0 || rd_data !== '0) begin
      errors++; $display("FAIL midreset_outs: tready=%b rd_data=%h required 0 0", axis.tready, rd_data); end
    @(negedge clk); rst = 1'b0;
    drive_beat(exp_word(8'hC0, 3), 4'hf, 1'b0, 1'b0, 1'b0);
    drive_beat(exp_word(8'hC0, 4), 4'hf, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    axis.tvalid = 1'b0; axis.tlast = 1'b0;
    checks++; if ({status_good_frame, status_bad_frame, status_overflow} !== 3'b000 || rd_frame_valid !== 1'b0) begin
      errors++; $display("FAIL trailing_discard: status=%b valid=%b required 000 0",
                         {status_good_frame, status_bad_frame, status_overflow}, rd_frame_valid); end
    send_frame(16, 8'h55, 1'b0, 1'b0);
    checks++; if (got_good !== 1'b1 || rd_frame_len !== 12'd16) begin
      errors++; $display("FAIL post_reset_commit: good=%b len=%0d required 1 16", got_good, rd_frame_len); end
    read_word('0, rword);
    checks++; if (rword !== 32'h58575655) begin errors++; $display("FAIL post_reset_data: got %h required 58575655", rword); end
  endtask

  initial begin
    got_good = 1'b0; got_bad = 1'b0; got_ovf = 1'b0; tready_low = 1'b0; rword = '0;
    test_reset();
    test_resync_small();
    test_two_slots_overflow();
    test_release_commit_same_edge();
    test_max_frame();
    test_bad_frame();
    test_reset_mid_recv();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
